// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline types: register index width, stage shadow record, forward-select codes.
package riscv_pipe_pkg;

    localparam int unsigned REG_ADDR_W = 5;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    // One pipeline stage's view of the instruction it holds.
    typedef struct packed {
        logic      valid;
        reg_addr_t rd;
        logic      we;
        logic      load;
    } stage_shadow_t;

    // Select code for the ID-stage operand forwarding mux.
    typedef enum logic [1:0] {
        FwdNone    = 2'b00,
        FwdMemRead = 2'b01,
        FwdAlu     = 2'b10
    } fwd_sel_e;

    // True when a live ID source operand is produced by the given stage (x0 never matches).
    function automatic logic reg_match(logic id_valid, logic uses, reg_addr_t rs,
                                       stage_shadow_t st);
        return id_valid & uses & (rs != '0) & st.valid & st.we & (st.rd == rs);
    endfunction

    // MEM-stage hit picks load data or the registered ALU result.
    function automatic fwd_sel_e fwd_select(logic hit, logic load);
        if (!hit) begin
            return FwdNone;
        end
        return load ? FwdMemRead : FwdAlu;
    endfunction

endpackage

// File: rtl/branch_hazard_detector_if.sv
// ID-stage hazard bus: decoded operand info in, stall/bubble/forward controls out.
interface branch_hazard_detector_if #(
    parameter int unsigned CNT_W = 16
);
    import riscv_pipe_pkg::*;

    logic             id_valid;
    logic             id_is_branch;
    logic             id_uses_rs1;
    logic             id_uses_rs2;
    reg_addr_t        id_rs1;
    reg_addr_t        id_rs2;
    reg_addr_t        id_rd;
    logic             id_reg_write;
    logic             id_mem_read;
    logic             flush;
    logic             stall;
    logic             ex_bubble;
    logic [CNT_W-1:0] stall_count;
    fwd_sel_e         fwd_rs1;
    fwd_sel_e         fwd_rs2;

    // Decode stage side.
    modport master (
        output id_valid, id_is_branch, id_uses_rs1, id_uses_rs2, id_rs1, id_rs2, id_rd,
               id_reg_write, id_mem_read, flush,
        input  stall, ex_bubble, stall_count, fwd_rs1, fwd_rs2
    );

    // Hazard unit side.
    modport slave (
        input  id_valid, id_is_branch, id_uses_rs1, id_uses_rs2, id_rs1, id_rs2, id_rd,
               id_reg_write, id_mem_read, flush,
        output stall, ex_bubble, stall_count, fwd_rs1, fwd_rs2
    );

endinterface

// File: rtl/stage_shadow_reg.sv
// One stage shadow record: bubble clears the record, enable loads it.
module stage_shadow_reg
    import riscv_pipe_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          bubble,
    input  stage_shadow_t d,
    output stage_shadow_t q
);

    // Record register; bubble wins over load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (bubble) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/branch_hazard_detector.sv
// ID-stage hazard unit: shadows EX/MEM destinations, stalls on hazards MEM forwarding
// cannot cover, drives MEM forward selects and counts stall cycles.
module branch_hazard_detector
    import riscv_pipe_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input logic                     clk,
    input logic                     rst,
    branch_hazard_detector_if.slave bus
);

    stage_shadow_t    ex_d;
    stage_shadow_t    ex_q;
    stage_shadow_t    mem_q;
    logic             ex_kill;
    logic             ex_hit1;
    logic             ex_hit2;
    logic             mem_hit1;
    logic             mem_hit2;
    logic             hazard;
    logic             stall;
    logic [CNT_W-1:0] stall_count_q;

    // Operand comparators and hazard decision; flush overrides any stall.
    always_comb begin
        ex_hit1  = reg_match(bus.id_valid, bus.id_uses_rs1, bus.id_rs1, ex_q);
        ex_hit2  = reg_match(bus.id_valid, bus.id_uses_rs2, bus.id_rs2, ex_q);
        mem_hit1 = reg_match(bus.id_valid, bus.id_uses_rs1, bus.id_rs1, mem_q);
        mem_hit2 = reg_match(bus.id_valid, bus.id_uses_rs2, bus.id_rs2, mem_q);
        // Branches need operands now, so any EX producer stalls; otherwise only a load does.
        hazard   = (ex_hit1 | ex_hit2) & (bus.id_is_branch | ex_q.load);
        stall    = hazard & ~bus.flush;
    end

    // Next EX record: the ID instruction unless it is held, killed or absent.
    always_comb begin
        ex_d.valid = 1'b1;
        ex_d.rd    = bus.id_rd;
        ex_d.we    = bus.id_reg_write;
        ex_d.load  = bus.id_mem_read;
        ex_kill    = stall | bus.flush | ~bus.id_valid;
    end

    stage_shadow_reg u_ex_shadow (
        .clk    (clk),
        .rst    (rst),
        .en     (1'b1),
        .bubble (ex_kill),
        .d      (ex_d),
        .q      (ex_q)
    );

    stage_shadow_reg u_mem_shadow (
        .clk    (clk),
        .rst    (rst),
        .en     (1'b1),
        .bubble (1'b0),
        .d      (ex_q),
        .q      (mem_q)
    );

    // Saturating stall-cycle counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_count_q <= '0;
        end else if (stall && (stall_count_q != {CNT_W{1'b1}})) begin
            stall_count_q <= stall_count_q + CNT_W'(1);
        end
    end

    assign bus.stall       = stall;
    assign bus.ex_bubble   = stall | bus.flush;
    assign bus.stall_count = stall_count_q;
    assign bus.fwd_rs1     = fwd_select(mem_hit1, mem_q.load);
    assign bus.fwd_rs2     = fwd_select(mem_hit2, mem_q.load);

endmodule
